// File: rtl/rv32i_clint.sv
// ============================================================================
// Module   : rv32i_clint
// Purpose  : Machine timer / software interrupt block (mtime, mtimecmp, msip)
//            on the SoC data bus. Optional CLINT_EXT_IRQ_SYNC_EN adds a
//            2-flop synchronizer on the external interrupt path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_clint #(
  parameter int          CLK_FREQ_MHZ = 100,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data_in,
  input  logic [3:0]  i_wr_mask,
  output logic        o_ack,
  output logic [31:0] o_data_out,
  input  logic        i_mtime_wr,
  input  logic [63:0] i_mtime_din,
  input  logic        i_mtimecmp_wr,
  input  logic [63:0] i_mtimecmp_din,
  input  logic        i_external_interrupt,
  output logic        o_timer_interrupt,
  output logic        o_software_interrupt,
  output logic        o_external_interrupt
);

  localparam int                   c_PRESC_W  = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(CLK_FREQ_MHZ - 1);

  localparam logic [2:0] c_OFF_MSIP    = 3'd0;
  localparam logic [2:0] c_OFF_CMP_LO  = 3'd2;
  localparam logic [2:0] c_OFF_CMP_HI  = 3'd3;
  localparam logic [2:0] c_OFF_TIME_LO = 3'd4;
  localparam logic [2:0] c_OFF_TIME_HI = 3'd5;

  logic [c_PRESC_W-1:0] r_presc;
  logic [63:0]          r_mtime;
  logic [63:0]          r_mtimecmp;
  logic                 r_msip;
  logic [31:0]          r_shadow;
  logic                 r_ack;
  logic [31:0]          r_rdata;
  logic                 r_timer_irq;

  logic        w_hit;
  logic        w_bus_wr;
  logic        w_bus_rd;
  logic [2:0]  w_off;
  logic        w_tick;
  logic        w_time_bus_wr;
  logic [31:0] w_rdata;
  logic        w_unused;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  assign w_hit         = i_stb && (i_addr[31:5] == BASE_ADDR[31:5]);
  assign w_off         = i_addr[4:2];
  assign w_bus_wr      = w_hit && i_wr_en;
  assign w_bus_rd      = w_hit && !i_wr_en;
  assign w_tick        = (r_presc == c_PRESC_MAX);
  assign w_time_bus_wr = w_bus_wr && ((w_off == c_OFF_TIME_LO) || (w_off == c_OFF_TIME_HI));
  assign w_unused      = &{1'b0, i_addr[1:0]};

  always_comb begin
    w_rdata = '0;
    case (w_off)
      c_OFF_MSIP:    w_rdata = {31'b0, r_msip};
      c_OFF_CMP_LO:  w_rdata = r_mtimecmp[31:0];
      c_OFF_CMP_HI:  w_rdata = r_mtimecmp[63:32];
      c_OFF_TIME_LO: w_rdata = r_mtime[31:0];
      c_OFF_TIME_HI: w_rdata = r_shadow;
      default:       w_rdata = '0;
    endcase
  end

  // Any explicit mtime load restarts the microsecond prescaler.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_mtime <= '0;
    end else begin
      if (i_mtime_wr || w_time_bus_wr || w_tick) r_presc <= '0;
      else                                        r_presc <= r_presc + 1'b1;

      if (i_mtime_wr)
        r_mtime <= i_mtime_din;
      else if (w_bus_wr && (w_off == c_OFF_TIME_LO))
        r_mtime[31:0] <= merge_bytes(r_mtime[31:0], i_data_in, i_wr_mask);
      else if (w_bus_wr && (w_off == c_OFF_TIME_HI))
        r_mtime[63:32] <= merge_bytes(r_mtime[63:32], i_data_in, i_wr_mask);
      else if (w_tick)
        r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      r_shadow   <= '0;
    end else begin
      if (i_mtimecmp_wr)
        r_mtimecmp <= i_mtimecmp_din;
      else if (w_bus_wr && (w_off == c_OFF_CMP_LO))
        r_mtimecmp[31:0] <= merge_bytes(r_mtimecmp[31:0], i_data_in, i_wr_mask);
      else if (w_bus_wr && (w_off == c_OFF_CMP_HI))
        r_mtimecmp[63:32] <= merge_bytes(r_mtimecmp[63:32], i_data_in, i_wr_mask);

      if (w_bus_wr && (w_off == c_OFF_MSIP) && i_wr_mask[0])
        r_msip <= i_data_in[0];

      // Low-half read freezes the high half so a 0x10/0x14 pair is coherent.
      if (w_bus_rd && (w_off == c_OFF_TIME_LO))
        r_shadow <= r_mtime[63:32];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack       <= 1'b0;
      r_rdata     <= '0;
      r_timer_irq <= 1'b0;
    end else begin
      r_ack       <= w_hit;
      r_timer_irq <= (r_mtime >= r_mtimecmp);
      if (w_bus_rd) r_rdata <= w_rdata;
    end
  end

`ifdef CLINT_EXT_IRQ_SYNC_EN
  logic [1:0] r_ext_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ext_sync <= 2'b00;
    else       r_ext_sync <= {r_ext_sync[0], i_external_interrupt};
  end

  assign o_external_interrupt = r_ext_sync[1];
`else
  assign o_external_interrupt = i_external_interrupt;
`endif

  assign o_ack                = r_ack;
  assign o_data_out           = r_rdata;
  assign o_timer_interrupt    = r_timer_irq;
  assign o_software_interrupt = r_msip;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_clint.sv
// ============================================================================
// Module   : tb_rv32i_clint
// Purpose  : Directed self-checking bench for rv32i_clint (vector table plus
//            hand-written timing sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_clint;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  wr_mask = '0;
  logic        ack;
  logic [31:0] data_out;
  logic        mtime_wr = 1'b0;
  logic [63:0] mtime_din = '0;
  logic        mtimecmp_wr = 1'b0;
  logic [63:0] mtimecmp_din = '0;
  logic        ext_in = 1'b0;
  logic        timer_irq;
  logic        sw_irq;
  logic        ext_out;

  int n_checks = 0;
  int n_fail   = 0;

  rv32i_clint #(.CLK_FREQ_MHZ(100), .BASE_ADDR(BASE)) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_stb                (stb),
    .i_wr_en              (wr_en),
    .i_addr               (addr),
    .i_data_in            (data_in),
    .i_wr_mask            (wr_mask),
    .o_ack                (ack),
    .o_data_out           (data_out),
    .i_mtime_wr           (mtime_wr),
    .i_mtime_din          (mtime_din),
    .i_mtimecmp_wr        (mtimecmp_wr),
    .i_mtimecmp_din       (mtimecmp_din),
    .i_external_interrupt (ext_in),
    .o_timer_interrupt    (timer_irq),
    .o_software_interrupt (sw_irq),
    .o_external_interrupt (ext_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        exp_ack;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus request; returns ack/data sampled just after the servicing edge.
  task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] m, output logic got_ack, output logic [31:0] rd);
    @(negedge clk);
    stb = 1'b1; wr_en = we; addr = a; data_in = wd; wr_mask = m;
    @(posedge clk);
    #1;
    got_ack = ack;
    rd      = data_out;
    stb = 1'b0; wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic        k;
    logic [31:0] d;
    bus(1'b0, a, 32'h0, 4'h0, k, d);
    check({name, "_ack"}, {63'b0, k}, 64'd1);
    check(name, {32'b0, d}, {32'b0, exp});
  endtask

  task automatic wr_chk(input string name, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m);
    logic        k;
    logic [31:0] d;
    bus(1'b1, a, wd, m, k, d);
    check({name, "_ack"}, {63'b0, k}, 64'd1);
  endtask

  task automatic direct_mtime(input logic [63:0] v);
    @(negedge clk);
    mtime_wr = 1'b1; mtime_din = v;
    @(posedge clk);
    #1 mtime_wr = 1'b0;
  endtask

  initial begin
    logic        k;
    logic [31:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack", {63'b0, ack}, 64'd0);
    check("rst_data", {32'b0, data_out}, 64'd0);
    check("rst_irqs", {61'b0, timer_irq, sw_irq, ext_out}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1000 cycles of 1 us ticks -> mtime 10
    repeat (1000) @(posedge clk);
    rd_chk("mtime_lo_10", BASE + 32'h10, 32'd10);
    rd_chk("cmp_hi_rst", BASE + 32'h0C, 32'hFFFF_FFFF);
    check("timer_idle", {63'b0, timer_irq}, 64'd0);

    // Timer compare: mtime=0, mtimecmp=15 loaded together
    @(negedge clk);
    mtime_wr = 1'b1; mtime_din = 64'd0;
    mtimecmp_wr = 1'b1; mtimecmp_din = 64'd15;
    @(posedge clk);
    #1 mtime_wr = 1'b0; mtimecmp_wr = 1'b0;
    repeat (1500) @(posedge clk);
    #1 check("timer_at_15_pre", {63'b0, timer_irq}, 64'd0);
    @(posedge clk);
    #1 check("timer_rise", {63'b0, timer_irq}, 64'd1);
    repeat (50) @(posedge clk);
    #1 check("timer_hold", {63'b0, timer_irq}, 64'd1);
    wr_chk("cmp_lo_ones", BASE + 32'h08, 32'hFFFF_FFFF, 4'hF);
    check("timer_lag", {63'b0, timer_irq}, 64'd1);
    wr_chk("cmp_hi_ones", BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF);
    check("timer_drop", {63'b0, timer_irq}, 64'd0);

    // Software interrupt
    wr_chk("msip_set", BASE, 32'h1, 4'b0001);
    check("sw_irq_set", {63'b0, sw_irq}, 64'd1);
    wr_chk("msip_clr", BASE, 32'h0, 4'b0001);
    check("sw_irq_clr", {63'b0, sw_irq}, 64'd0);

    // Register map vectors
    vq.push_back('{1'b1, BASE + 32'h00, 32'h0000_0001, 4'b0001, 1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b0, BASE + 32'h00, 32'h0,         4'b0000, 1'b1, 1'b1, 32'h0000_0001});
    vq.push_back('{1'b1, BASE + 32'h00, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b0, BASE + 32'h00, 32'h0,         4'b0000, 1'b1, 1'b1, 32'h0000_0001});
    vq.push_back('{1'b1, BASE + 32'h00, 32'hFFFF_FFFE, 4'b1111, 1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b0, BASE + 32'h00, 32'h0,         4'b0000, 1'b1, 1'b1, 32'h0000_0000});
    vq.push_back('{1'b1, BASE + 32'h00, 32'hFFFF_FFFF, 4'b1111, 1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b0, BASE + 32'h00, 32'h0,         4'b0000, 1'b1, 1'b1, 32'h0000_0001});
    vq.push_back('{1'b1, BASE + 32'h08, 32'h1234_5678, 4'b0101, 1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b0, BASE + 32'h08, 32'h0,         4'b0000, 1'b1, 1'b1, 32'hFF34_FF78});
    vq.push_back('{1'b1, BASE + 32'h0C, 32'hAABB_CCDD, 4'b1000, 1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b0, BASE + 32'h0C, 32'h0,         4'b0000, 1'b1, 1'b1, 32'hAAFF_FFFF});
    vq.push_back('{1'b0, BASE + 32'h04, 32'h0,         4'b0000, 1'b1, 1'b1, 32'h0000_0000});
    vq.push_back('{1'b1, BASE + 32'h18, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b0, BASE + 32'h18, 32'h0,         4'b0000, 1'b1, 1'b1, 32'h0000_0000});
    vq.push_back('{1'b0, BASE + 32'h1C, 32'h0,         4'b0000, 1'b1, 1'b1, 32'h0000_0000});
    vq.push_back('{1'b0, BASE + 32'h20, 32'h0,         4'b0000, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b1, 32'h7FFF_FFF0, 32'h0,         4'b1111, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b1, BASE + 32'h08, 32'hFFFF_FFFF, 4'b1111, 1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b1, BASE + 32'h0C, 32'hFFFF_FFFF, 4'b1111, 1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b1, BASE + 32'h00, 32'h0000_0000, 4'b0001, 1'b1, 1'b0, 32'h0});

    foreach (vq[i]) begin
      bus(vq[i].we, vq[i].addr, vq[i].wdata, vq[i].mask, k, d);
      check($sformatf("vec%0d_ack", i), {63'b0, k}, {63'b0, vq[i].exp_ack});
      if (vq[i].chk_data)
        check($sformatf("vec%0d_data", i), {32'b0, d}, {32'b0, vq[i].exp_data});
    end
    check("sw_irq_after_vec", {63'b0, sw_irq}, 64'd0);

    // Coherent 64-bit read across a carry
    direct_mtime(64'h0000_0000_FFFF_FFFF);
    rd_chk("coh_lo", BASE + 32'h10, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("ack_single", {63'b0, ack}, 64'd0);
    check("data_hold", {32'b0, data_out}, 64'h0000_0000_FFFF_FFFF);
    repeat (110) @(posedge clk);
    rd_chk("coh_hi_shadow", BASE + 32'h14, 32'h0000_0000);
    rd_chk("live_lo", BASE + 32'h10, 32'h0000_0000);
    rd_chk("live_hi", BASE + 32'h14, 32'h0000_0001);

    // Direct write beats bus write on a tick cycle
    direct_mtime(64'd0);
    repeat (99) @(posedge clk);
    @(negedge clk);
    mtime_wr = 1'b1; mtime_din = 64'd5;
    stb = 1'b1; wr_en = 1'b1; addr = BASE + 32'h10; data_in = 32'd9; wr_mask = 4'hF;
    @(posedge clk);
    #1;
    check("prio_ack", {63'b0, ack}, 64'd1);
    mtime_wr = 1'b0; stb = 1'b0; wr_en = 1'b0;
    rd_chk("prio_mtime", BASE + 32'h10, 32'd5);
    repeat (97) @(posedge clk);
    rd_chk("prio_e99", BASE + 32'h10, 32'd5);
    rd_chk("prio_e100", BASE + 32'h10, 32'd5);
    rd_chk("prio_e101", BASE + 32'h10, 32'd6);

    // Bus write to mtime high half restarts the prescaler
    wr_chk("mtime_hi_wr", BASE + 32'h14, 32'h0, 4'hF);
    repeat (98) @(posedge clk);
    rd_chk("bw_e99", BASE + 32'h10, 32'd6);
    rd_chk("bw_e100", BASE + 32'h10, 32'd6);
    rd_chk("bw_e101", BASE + 32'h10, 32'd7);

    // External interrupt path
`ifdef CLINT_EXT_IRQ_SYNC_EN
    @(negedge clk);
    ext_in = 1'b1;
    @(posedge clk);
    #1 check("ext_sync_c1", {63'b0, ext_out}, 64'd0);
    @(negedge clk);
    ext_in = 1'b0;
    @(posedge clk);
    #1 check("ext_sync_c2", {63'b0, ext_out}, 64'd1);
    @(posedge clk);
    #1 check("ext_sync_c3", {63'b0, ext_out}, 64'd0);
`else
    @(negedge clk);
    ext_in = 1'b1;
    #1 check("ext_pass_hi", {63'b0, ext_out}, 64'd1);
    @(negedge clk);
    ext_in = 1'b0;
    #1 check("ext_pass_lo", {63'b0, ext_out}, 64'd0);
`endif

    // Reset in the middle of a transaction
    wr_chk("msip_pre_rst", BASE, 32'h1, 4'b0001);
    direct_mtime(64'h0000_1234_0000_0000);
    rd_chk("shadow_load", BASE + 32'h10, 32'h0);
    @(negedge clk);
    stb = 1'b1; wr_en = 1'b0; addr = BASE + 32'h0C;
    @(posedge clk);
    #1 stb = 1'b0;
    check("pend_ack", {63'b0, ack}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_drop_ack", {63'b0, ack}, 64'd0);
    check("rst_data2", {32'b0, data_out}, 64'd0);
    check("rst_sw_irq", {63'b0, sw_irq}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("rst_shadow", BASE + 32'h14, 32'h0);
    rd_chk("rst_cmp_lo", BASE + 32'h08, 32'hFFFF_FFFF);
    rd_chk("rst_msip", BASE + 32'h00, 32'h0);
    rd_chk("rst_mtime", BASE + 32'h10, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
